pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_RESET, default 64'h0, first fetch address after reset.
REQ-002 Parameter PC_STEP, default 64'h1, sequential increment (word-addressed).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 branch_valid  input  1  one-cycle redirect request from branch unit.
REQ-006 branch_target  input  64  redirect address; sampled only when branch_valid=1.
REQ-007 stall  input  1  hazard unit holds fetch; no new request issued while high.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  64  request address.
REQ-010 imem_ack  input  1  memory completion; meaningful only while imem_req=1.
REQ-011 fetch_valid  output  1  one-cycle pulse: accepted fetch for decode.
REQ-012 fetch_pc  output  64  address of the accepted fetch; valid with fetch_valid.

Function
REQ-013 FSM states: BOOT, ISSUE, WAIT_ACK, HOLD; BOOT -> ISSUE unconditionally after one cycle.
REQ-014 ISSUE/WAIT_ACK drive imem_req=1, imem_addr=pc; imem_addr stays stable until imem_ack.
REQ-015 ISSUE without imem_ack -> WAIT_ACK; WAIT_ACK holds until imem_ack.
REQ-016 imem_ack with no redirect: fetch_valid=1, fetch_pc=pc next cycle; pc <= pc+PC_STEP.
REQ-017 pc arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
REQ-018 After ack: stall=1 -> HOLD (imem_req=0); stall=0 -> ISSUE (back-to-back, zero bubble).
REQ-019 HOLD -> ISSUE in the first cycle stall=0; stall while WAIT_ACK does not abort the outstanding request.
REQ-020 branch_valid while request outstanding: latch target into redirect_pending; later branch overwrites.
REQ-021 Ack with redirect pending: fetch_valid suppressed, pc <= latched target, pending cleared.
REQ-022 branch_valid in same cycle as imem_ack: response dropped, pc <= branch_target (new target wins).
REQ-023 branch_valid in BOOT or HOLD: pc <= branch_target immediately; no fetch_valid.
REQ-024 fetch_valid never asserted for two accepts without an intervening ack; max one outstanding request.

Reset
REQ-025 rst=1 asynchronously forces: state=BOOT, pc=PC_RESET, redirect_pending=0, imem_req=0, fetch_valid=0, fetch_pc=0.
REQ-026 rst mid-request abandons the outstanding request; any later imem_ack is ignored until ISSUE is re-entered.

Configuration
REQ-027 Macro PC_SEQ_TRAP_EN defined: adds input trap_valid (1 bit) and parameter TRAP_VECTOR (default 64'h100).
REQ-028 With PC_SEQ_TRAP_EN: trap_valid uses branch redirect rules with target TRAP_VECTOR, priority over same-cycle branch_valid.
REQ-029 Without PC_SEQ_TRAP_EN: no trap_valid port, no TRAP_VECTOR; behaviour per REQ-013..026 only.

Structure
REQ-030 Package pc_seq_pkg holds the FSM state typedef, the 64-bit address typedef and default PC_RESET/PC_STEP/TRAP_VECTOR constants.
REQ-031 One sub-module pc_redirect_sel: combinational trap/branch/pending priority select producing next-pc and drop flag.

Verification
REQ-032 Reset release, imem_ack tied 1 -> fetch_pc 0,1,2,3 on consecutive cycles, fetch_valid continuous.
REQ-033 ack delayed 3 cycles at pc=5 -> imem_addr=5 held stable 4 cycles, single fetch_valid with fetch_pc=5.
REQ-034 branch_valid target=0x40 while waiting at pc=7 -> pc=7 response dropped, next imem_addr=0x40.
REQ-035 stall=1 for 4 cycles after ack at pc=2 -> imem_req=0 throughout, resumes with imem_addr=3.
REQ-036 pc forced via branch to 64'hFFFF_FFFF_FFFF_FFFF, ack -> next imem_addr=0.
REQ-037 (PC_SEQ_TRAP_EN) trap_valid and branch_valid(0x80) same cycle -> next imem_addr=0x100.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the pc_sequencer fetch front end.
// The optional trap redirect (macro PC_SEQ_TRAP_EN) uses TRAP_VECTOR_DEF as its default vector.
`timescale 1ns/1ps
package pc_seq_pkg;

    typedef logic [63:0] addr_t;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    localparam addr_t PC_RESET_DEF    = 64'h0;
    localparam addr_t PC_STEP_DEF     = 64'h1;
    localparam addr_t TRAP_VECTOR_DEF = 64'h100;

    // Sequential advance; the 64-bit result truncates, so the top address wraps to zero.
    function automatic addr_t pc_advance(input addr_t pc, input addr_t step);
        return pc + step;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational next-pc select: trap > branch > pending redirect > sequential advance.
// The trap input exists only when PC_SEQ_TRAP_EN is defined.
`timescale 1ns/1ps
module pc_redirect_sel
    import pc_seq_pkg::*;
#(
    parameter addr_t PC_STEP = PC_STEP_DEF
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter addr_t TRAP_VECTOR = TRAP_VECTOR_DEF
`endif
) (
    input  logic  accept_i,
    input  logic  idle_i,
    input  logic  branch_valid_i,
    input  addr_t branch_target_i,
`ifdef PC_SEQ_TRAP_EN
    input  logic  trap_valid_i,
`endif
    input  logic  pend_valid_i,
    input  addr_t pend_target_i,
    input  addr_t pc_i,
    output addr_t next_pc_o,
    output logic  drop_o,
    output logic  pend_set_o,
    output logic  pend_clr_o,
    output addr_t redir_target_o
);

    logic  redir_now;
    addr_t redir_tgt;

    always_comb begin
        redir_now = branch_valid_i;
        redir_tgt = branch_target_i;
`ifdef PC_SEQ_TRAP_EN
        if (trap_valid_i) begin
            redir_now = 1'b1;
            redir_tgt = TRAP_VECTOR;
        end
`endif
    end

    always_comb begin
        next_pc_o  = pc_i;
        drop_o     = 1'b0;
        pend_set_o = 1'b0;
        pend_clr_o = 1'b0;
        if (accept_i) begin
            // A same-cycle redirect beats an older pending one; either drops the response.
            pend_clr_o = 1'b1;
            if (redir_now) begin
                next_pc_o = redir_tgt;
                drop_o    = 1'b1;
            end else if (pend_valid_i) begin
                next_pc_o = pend_target_i;
                drop_o    = 1'b1;
            end else begin
                next_pc_o = pc_advance(pc_i, PC_STEP);
            end
        end else if (idle_i) begin
            if (redir_now) begin
                next_pc_o = redir_tgt;
            end
        end else begin
            // Request outstanding: park the redirect so imem_addr stays stable until ack.
            pend_set_o = redir_now;
        end
    end

    assign redir_target_o = redir_tgt;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer: one outstanding imem request, branch redirects, stall hold.
// Define PC_SEQ_TRAP_EN to add the trap_valid input and TRAP_VECTOR parameter.
`timescale 1ns/1ps
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter addr_t PC_RESET = PC_RESET_DEF,
    parameter addr_t PC_STEP  = PC_STEP_DEF
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter addr_t TRAP_VECTOR = TRAP_VECTOR_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_valid,
    input  logic [63:0] branch_target,
    input  logic        stall,
`ifdef PC_SEQ_TRAP_EN
    input  logic        trap_valid,
`endif
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    output logic        fetch_valid,
    output logic [63:0] fetch_pc
);

    state_e state_q, state_d;
    addr_t  pc_q, pc_d;
    logic   pend_valid_q, pend_valid_d;
    addr_t  pend_tgt_q, pend_tgt_d;
    logic   fetch_valid_q, fetch_valid_d;
    addr_t  fetch_pc_q, fetch_pc_d;

    logic  accept;
    logic  idle;
    addr_t next_pc;
    logic  drop;
    logic  pend_set;
    logic  pend_clr;
    addr_t redir_tgt;

    pc_redirect_sel #(
        .PC_STEP         (PC_STEP)
`ifdef PC_SEQ_TRAP_EN
        ,
        .TRAP_VECTOR     (TRAP_VECTOR)
`endif
    ) u_redirect_sel (
        .accept_i        (accept),
        .idle_i          (idle),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
`ifdef PC_SEQ_TRAP_EN
        .trap_valid_i    (trap_valid),
`endif
        .pend_valid_i    (pend_valid_q),
        .pend_target_i   (pend_tgt_q),
        .pc_i            (pc_q),
        .next_pc_o       (next_pc),
        .drop_o          (drop),
        .pend_set_o      (pend_set),
        .pend_clr_o      (pend_clr),
        .redir_target_o  (redir_tgt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:     state_d = ST_ISSUE;
            ST_ISSUE,
            ST_WAIT_ACK: begin
                if (imem_ack) begin
                    state_d = stall ? ST_HOLD : ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_HOLD:     state_d = stall ? ST_HOLD : ST_ISSUE;
            default:     state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK);
        imem_addr = pc_q;
        accept    = imem_req && imem_ack;
        idle      = (state_q == ST_BOOT) || (state_q == ST_HOLD);
    end

    always_comb begin
        pc_d          = next_pc;
        pend_valid_d  = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pend_valid_q);
        pend_tgt_d    = pend_set ? redir_tgt : pend_tgt_q;
        fetch_valid_d = accept && !drop;
        fetch_pc_d    = (accept && !drop) ? pc_q : fetch_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RESET;
            pend_valid_q  <= 1'b0;
            pend_tgt_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_tgt_q    <= pend_tgt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a transaction-level reference model checked every cycle.
// Define PC_SEQ_TRAP_EN to also exercise the trap redirect.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        branch_valid;
    logic [63:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
`ifdef PC_SEQ_TRAP_EN
    logic        trap_valid;
    logic        trap_req;
`endif

    int checks;
    int errors;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
`ifdef PC_SEQ_TRAP_EN
        .trap_valid    (trap_valid),
`endif
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a booting flag, a held flag, the pc, one parked redirect.
    logic        m_boot, m_hold, m_pend_v, m_fv;
    logic [63:0] m_pc, m_pend_t, m_fpc;
    logic        n_hold, n_pend_v, n_fv;
    logic [63:0] n_pc, n_pend_t, n_fpc;
    logic        m_req, redir;
    logic [63:0] tgt;

    always_comb begin
        m_req    = !m_boot && !m_hold;
        redir    = branch_valid;
        tgt      = branch_target;
`ifdef PC_SEQ_TRAP_EN
        if (trap_valid) begin
            redir = 1'b1;
            tgt   = 64'h100;
        end
`endif
        n_hold   = m_hold;
        n_pc     = m_pc;
        n_pend_v = m_pend_v;
        n_pend_t = m_pend_t;
        n_fv     = 1'b0;
        n_fpc    = m_fpc;
        if (m_req && imem_ack) begin
            n_pend_v = 1'b0;
            n_hold   = stall;
            if (redir) begin
                n_pc = tgt;
            end else if (m_pend_v) begin
                n_pc = m_pend_t;
            end else begin
                n_fv  = 1'b1;
                n_fpc = m_pc;
                n_pc  = m_pc + 64'd1;
            end
        end else if (m_req) begin
            if (redir) begin
                n_pend_v = 1'b1;
                n_pend_t = tgt;
            end
        end else begin
            if (redir) n_pc = tgt;
            n_hold = m_boot ? 1'b0 : stall;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot   <= 1'b1;
            m_hold   <= 1'b0;
            m_pc     <= 64'h0;
            m_pend_v <= 1'b0;
            m_pend_t <= 64'h0;
            m_fv     <= 1'b0;
            m_fpc    <= 64'h0;
        end else begin
            m_boot   <= 1'b0;
            m_hold   <= n_hold;
            m_pc     <= n_pc;
            m_pend_v <= n_pend_v;
            m_pend_t <= n_pend_t;
            m_fv     <= n_fv;
            m_fpc    <= n_fpc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_imem_req", {63'd0, imem_req}, {63'd0, m_req});
        if (m_req) chk("model_imem_addr", imem_addr, m_pc);
        chk("model_fetch_valid", {63'd0, fetch_valid}, {63'd0, m_fv});
        if (m_fv) chk("model_fetch_pc", fetch_pc, m_fpc);
    endtask

    task automatic step(input logic bv, input logic [63:0] t, input logic st, input logic ack);
        @(posedge clk);
        #1;
        branch_valid  = bv;
        branch_target = t;
        stall         = st;
        imem_ack      = ack;
`ifdef PC_SEQ_TRAP_EN
        trap_valid = trap_req;
        trap_req   = 1'b0;
`endif
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 64'h0;
        stall         = 1'b0;
        imem_ack      = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        trap_valid = 1'b0;
        trap_req   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_model();
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst_fetch_pc", fetch_pc, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare_model();
        chk("boot_no_req", {63'd0, imem_req}, 64'd0);

        // Ack tied high: back-to-back fetches 0,1,2,3.
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("s1_addr", imem_addr, 64'd0);
        chk("s1_req", {63'd0, imem_req}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 64'h0, 1'b0, 1'b1);
            chk("seq_fetch_valid", {63'd0, fetch_valid}, 64'd1);
            chk("seq_fetch_pc", fetch_pc, 64'(i));
        end
        chk("s5_addr", imem_addr, 64'd4);

        // Ack delayed three cycles at pc=5.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 64'h0, 1'b0, 1'b0);
            chk("wait_addr5", imem_addr, 64'd5);
            if (i > 0) chk("wait_no_fetch", {63'd0, fetch_valid}, 64'd0);
        end
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("ack_addr5", imem_addr, 64'd5);
        chk("ack_no_fetch_yet", {63'd0, fetch_valid}, 64'd0);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("fetch5_valid", {63'd0, fetch_valid}, 64'd1);
        chk("fetch5_pc", fetch_pc, 64'd5);
        chk("addr6", imem_addr, 64'd6);

        // Branch while waiting at pc=7 drops that response.
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("addr7", imem_addr, 64'd7);
        step(1'b1, 64'h40, 1'b0, 1'b0);
        chk("addr7_hold_on_branch", imem_addr, 64'd7);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("addr7_ack", imem_addr, 64'd7);
        step(1'b1, 64'h10, 1'b0, 1'b1);
        chk("drop7_no_fetch", {63'd0, fetch_valid}, 64'd0);
        chk("redirect_addr40", imem_addr, 64'h40);
        step(1'b1, 64'h20, 1'b0, 1'b0);
        chk("same_cycle_branch_no_fetch", {63'd0, fetch_valid}, 64'd0);
        chk("same_cycle_addr10", imem_addr, 64'h10);
        step(1'b1, 64'h30, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b1, 64'h2, 1'b0, 1'b1);
        chk("overwrite_no_fetch", {63'd0, fetch_valid}, 64'd0);
        chk("overwrite_addr30", imem_addr, 64'h30);

        // Stall for four cycles after ack at pc=2.
        step(1'b0, 64'h0, 1'b1, 1'b1);
        chk("addr2", imem_addr, 64'd2);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("fetch2_valid", {63'd0, fetch_valid}, 64'd1);
        chk("fetch2_pc", fetch_pc, 64'd2);
        chk("hold_req0_a", {63'd0, imem_req}, 64'd0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("hold_req0_b", {63'd0, imem_req}, 64'd0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("hold_req0_c", {63'd0, imem_req}, 64'd0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("hold_req0_d", {63'd0, imem_req}, 64'd0);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        chk("resume_req", {63'd0, imem_req}, 64'd1);
        chk("resume_addr3", imem_addr, 64'd3);

        // Wrap from the top address.
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("addr_max", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("fetch_max_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_addr0", imem_addr, 64'd0);

        // Stall during WAIT_ACK keeps the request; branch in HOLD redirects at once.
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("stall_wait_req", {63'd0, imem_req}, 64'd1);
        step(1'b0, 64'h0, 1'b1, 1'b1);
        step(1'b1, 64'h77, 1'b1, 1'b0);
        chk("hold_fetch0", fetch_pc, 64'd0);
        chk("hold_req0_e", {63'd0, imem_req}, 64'd0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("hold_branch_no_fetch", {63'd0, fetch_valid}, 64'd0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("hold_branch_addr77", imem_addr, 64'h77);

        // Asynchronous reset in the middle of an outstanding request.
        @(posedge clk);
        #1;
        rst      = 1'b1;
        imem_ack = 1'b0;
        #1;
        chk("async_rst_req", {63'd0, imem_req}, 64'd0);
        chk("async_rst_fetch_pc", fetch_pc, 64'd0);
        imem_ack = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare_model();
        chk("post_rst_boot_req", {63'd0, imem_req}, 64'd0);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("post_rst_addr0", imem_addr, 64'd0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("post_rst_fetch0", {63'd0, fetch_valid}, 64'd1);
        chk("post_rst_addr1", imem_addr, 64'd1);

`ifdef PC_SEQ_TRAP_EN
        trap_req = 1'b1;
        step(1'b1, 64'h80, 1'b0, 1'b1);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("trap_no_fetch", {63'd0, fetch_valid}, 64'd0);
        chk("trap_addr100", imem_addr, 64'h100);
`endif

        step(1'b0, 64'h0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
